// File: rtl/div_seq_ctrl_pkg.sv
// rtl/div_seq_ctrl_pkg.sv - M-extension divide opcode, execute-to-divider bundle and op decode helpers
package div_seq_ctrl_pkg;

  localparam int DIV_XLEN = 32;

  typedef enum logic [2:0] {
    DIV_OPS_NONE = 3'd0,
    DIV_OPS_DIV  = 3'd1,
    DIV_OPS_DIVU = 3'd2,
    DIV_OPS_REM  = 3'd3,
    DIV_OPS_REMU = 3'd4
  } type_alu_d_ops_e;

  typedef struct packed {
    logic [DIV_XLEN-1:0] alu_operand_1;
    logic [DIV_XLEN-1:0] alu_operand_2;
    type_alu_d_ops_e     alu_d_ops;
  } type_exe2div_s;

  // Encodings 5..7 fall through to "not an op".
  function automatic logic op_is_valid(input type_alu_d_ops_e op);
    return (op == DIV_OPS_DIV) || (op == DIV_OPS_DIVU) ||
           (op == DIV_OPS_REM) || (op == DIV_OPS_REMU);
  endfunction

  function automatic logic op_is_signed(input type_alu_d_ops_e op);
    return (op == DIV_OPS_DIV) || (op == DIV_OPS_REM);
  endfunction

  function automatic logic op_is_rem(input type_alu_d_ops_e op);
    return (op == DIV_OPS_REM) || (op == DIV_OPS_REMU);
  endfunction

endpackage

// File: rtl/div_iter_dp.sv
// rtl/div_iter_dp.sv - restoring-division datapath: rem/quo/divisor registers with one shift-subtract step per enable
module div_iter_dp
  import div_seq_ctrl_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;

  // Shifted remainder needs one extra bit: it can reach 2*divisor-1 before the trial subtract.
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          no_borrow;

  assign rem_sh    = {rem_q, quo_q[XLEN-1]};
  assign diff      = rem_sh - {1'b0, dvs_q};
  assign no_borrow = ~diff[XLEN];

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (step_i) begin
      quo_d = {quo_q[XLEN-2:0], no_borrow};
      rem_d = no_borrow ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle divide/remainder sequencer with RISC-V sign and special-case handling
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  type_exe2div_s   exe2div_i,
  input  logic            div_kill_i,
  output logic            div_stall_o,
  output logic            div_valid_o,
  output logic [XLEN-1:0] div_result_o
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  type_alu_d_ops_e op_q, op_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] spec_res_q, spec_res_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            dp_load;
  logic            dp_step;
  logic [XLEN-1:0] dp_quo;
  logic [XLEN-1:0] dp_rem;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  type_alu_d_ops_e op_in;
  logic            in_valid;
  logic            in_signed;
  logic            start;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            sgn_ovf;
  logic [XLEN-1:0] fix_res;

  assign op_a      = exe2div_i.alu_operand_1[XLEN-1:0];
  assign op_b      = exe2div_i.alu_operand_2[XLEN-1:0];
  assign op_in     = exe2div_i.alu_d_ops;
  assign in_valid  = op_is_valid(op_in);
  assign in_signed = op_is_signed(op_in);
  assign start     = in_valid & ~div_kill_i;

  assign a_neg = in_signed & op_a[XLEN-1];
  assign b_neg = in_signed & op_b[XLEN-1];
  assign a_mag = a_neg ? (~op_a + 1'b1) : op_a;
  assign b_mag = b_neg ? (~op_b + 1'b1) : op_b;

  assign div_zero = (op_b == '0);
  assign sgn_ovf  = in_signed & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);

  // Quotient negates when signs differ; remainder follows the dividend.
  always_comb begin
    fix_res = '0;
    if (special_q) begin
      fix_res = spec_res_q;
    end else if (op_is_rem(op_q)) begin
      fix_res = neg_rem_q ? (~dp_rem + 1'b1) : dp_rem;
    end else begin
      fix_res = neg_quo_q ? (~dp_quo + 1'b1) : dp_quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= DIV_OPS_NONE;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op_in;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (div_zero || sgn_ovf) begin
            special_d = 1'b1;
            if (div_zero) begin
              spec_res_d = op_is_rem(op_in) ? op_a : '1;
            end else begin
              spec_res_d = op_is_rem(op_in) ? '0 : op_a;
            end
            state_d = ST_DONE;
          end else begin
            special_d = 1'b0;
            dp_load   = 1'b1;
            cnt_d     = '0;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        dp_step = ~div_kill_i;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!div_kill_i) begin
          result_d = fix_res;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (div_kill_i) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    div_stall_o  = 1'b0;
    div_valid_o  = 1'b0;
    div_result_o = result_q;
    case (state_q)
      ST_IDLE: div_stall_o = start;
      ST_BUSY: div_stall_o = ~div_kill_i;
      ST_DONE: begin
        div_valid_o = ~div_kill_i;
        if (!div_kill_i) begin
          div_result_o = fix_res;
        end
      end
      default: ;
    endcase
  end

  div_iter_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (dp_load),
    .step_i    (dp_step),
    .dividend_i(a_mag),
    .divisor_i (b_mag),
    .quo_o     (dp_quo),
    .rem_o     (dp_rem)
  );

endmodule
